// File: rtl/stage_memory_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_pkg
//  Description : Shared definitions for the memory pipeline stage.
//                - state encodings for the access FSM
//                - funct3 access-size/sign constants
//                - helpers for byte enables, store lane replication and
//                  alignment checking
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    // Access FSM state encoding
    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_ACCESS = 1'b1;

    // funct3 access size / sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Store byte enables; anything that is not SB/SH is a full word.
    function automatic logic [3:0] store_be(input logic [2:0] funct3,
                                            input logic [1:0] offset);
        case (funct3)
            F3_B:    store_be = 4'b0001 << offset;
            F3_H:    store_be = 4'b0011 << offset;
            default: store_be = 4'b1111;
        endcase
    endfunction

    // Replicate the store operand onto every lane so the byte enables alone
    // pick which lanes the memory writes.
    function automatic logic [31:0] store_lanes(input logic [2:0]  funct3,
                                                input logic [31:0] data);
        case (funct3)
            F3_B:    store_lanes = {4{data[7:0]}};
            F3_H:    store_lanes = {2{data[15:0]}};
            default: store_lanes = data;
        endcase
    endfunction

    // Alignment check. Stores only know SB/SH as sub-word sizes, loads also
    // have the unsigned variants; every other code is a word access.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] offset,
                                           input logic       is_store);
        logic w_byte;
        logic w_half;
        if (is_store) begin
            w_byte = (funct3 == F3_B);
            w_half = (funct3 == F3_H);
        end else begin
            w_byte = (funct3 == F3_B) || (funct3 == F3_BU);
            w_half = (funct3 == F3_H) || (funct3 == F3_HU);
        end
        if (w_byte)      is_misaligned = 1'b0;
        else if (w_half) is_misaligned = offset[0];
        else             is_misaligned = |offset;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stage_memory_load_extend.sv
`default_nettype none
// ============================================================================
//  Module      : load_extend
//  Description : Combinational load data alignment and extension. Selects the
//                byte or halfword lane addressed by the low address bits and
//                sign- or zero-extends it according to funct3.
//  Ports       : i_rdata  [31:0] raw read word from memory
//                i_offset [1:0]  byte offset of the access within the word
//                i_funct3 [2:0]  access size/sign
//                o_data   [31:0] extended load value
//  Revision    : 1.0 - initial release
// ============================================================================
module load_extend
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
    end

    assign w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'd0, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/stage_memory.sv
`default_nettype none
// ============================================================================
//  Module      : stage_memory
//  Description : Memory pipeline stage. Takes the EX/MEM slot, performs loads
//                and stores over a req/ready handshake to a variable-latency
//                data memory, and registers the MEM/WB result. The upstream
//                pipeline is frozen while an access is outstanding.
//  Ports       : clk, reset                  clock, synchronous active-high reset
//                in_*                        EX/MEM slot (address, store data,
//                                            funct3, rd, control bits)
//                out_stall                   freeze upstream (combinational)
//                mem_req/we/addr/wdata/be    registered memory request
//                mem_ready, mem_rdata        memory response
//                out_*                       MEM/WB register incl. exception flags
//  Revision    : 1.0 - initial release
// ============================================================================
module stage_memory
    import mem_stage_pkg::*;
#(
    parameter int LATENCY_MAX = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_alu_out,
    input  logic [31:0] in_mem_in_data,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic        in_mem_to_reg,
    input  logic        in_write_enable,
    output logic        out_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [4:0]  out_rd,
    output logic        out_write_enable,
    output logic        out_mem_to_reg,
    output logic [31:0] out_alu_out,
    output logic [31:0] out_mem_data,
    output logic        out_misaligned,
    output logic        out_timeout
);

    localparam int                 c_CNT_W    = $clog2(LATENCY_MAX);
    // The abort happens in the cycle whose increment would bring the counter
    // to LATENCY_MAX-1, so the request is up for exactly LATENCY_MAX-1 cycles.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(LATENCY_MAX - 2);

    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [4:0]         r_rd;
    logic               r_write_enable;
    logic               r_mem_to_reg;
    logic [31:0]        r_alu_out;
    logic               r_is_load;
    logic [2:0]         r_funct3;
    logic [1:0]         r_offset;

    logic               w_mem_op;
    logic               w_misaligned;
    logic               w_issue;
    logic               w_last;
    logic [31:0]        w_load_data;

    assign w_mem_op     = in_valid & (in_mem_read | in_mem_write);
    assign w_misaligned = w_mem_op & is_misaligned(in_funct3, in_alu_out[1:0], in_mem_write);
    assign w_issue      = w_mem_op & ~w_misaligned;
    assign w_last       = (r_cnt == c_CNT_LAST);

    // Never a function of mem_rdata: ready or abort alone releases upstream.
    always_comb begin
        out_stall = 1'b0;
        if (r_state == c_ST_IDLE) out_stall = w_issue;
        else                      out_stall = ~(mem_ready | w_last);
    end

    // Uses the latched offset/funct3, since mem_addr is word-aligned.
    load_extend u_load_extend (
        .i_rdata  (mem_rdata),
        .i_offset (r_offset),
        .i_funct3 (r_funct3),
        .o_data   (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= c_ST_IDLE;
            r_cnt            <= '0;
            r_rd             <= '0;
            r_write_enable   <= 1'b0;
            r_mem_to_reg     <= 1'b0;
            r_alu_out        <= '0;
            r_is_load        <= 1'b0;
            r_funct3         <= '0;
            r_offset         <= '0;
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            mem_be           <= '0;
            out_valid        <= 1'b0;
            out_rd           <= '0;
            out_write_enable <= 1'b0;
            out_mem_to_reg   <= 1'b0;
            out_alu_out      <= '0;
            out_mem_data     <= '0;
            out_misaligned   <= 1'b0;
            out_timeout      <= 1'b0;
        end else begin
            // MEM/WB defaults to a bubble; each case below overrides it.
            out_valid        <= 1'b0;
            out_rd           <= '0;
            out_write_enable <= 1'b0;
            out_mem_to_reg   <= 1'b0;
            out_alu_out      <= '0;
            out_mem_data     <= '0;
            out_misaligned   <= 1'b0;
            out_timeout      <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (w_issue) begin
                        r_state        <= c_ST_ACCESS;
                        r_cnt          <= '0;
                        r_rd           <= in_rd;
                        r_write_enable <= in_write_enable;
                        r_mem_to_reg   <= in_mem_to_reg;
                        r_alu_out      <= in_alu_out;
                        r_is_load      <= in_mem_read & ~in_mem_write;
                        r_funct3       <= in_funct3;
                        r_offset       <= in_alu_out[1:0];
                        mem_req        <= 1'b1;
                        mem_we         <= in_mem_write;
                        mem_addr       <= {in_alu_out[31:2], 2'b00};
                        mem_wdata      <= in_mem_write ? store_lanes(in_funct3, in_mem_in_data) : 32'd0;
                        mem_be         <= in_mem_write ? store_be(in_funct3, in_alu_out[1:0]) : 4'b1111;
                    end else if (w_misaligned) begin
                        out_valid      <= 1'b1;
                        out_misaligned <= 1'b1;
                        out_rd         <= in_rd;
                        out_mem_to_reg <= in_mem_to_reg;
                        out_alu_out    <= in_alu_out;
                    end else if (in_valid) begin
                        out_valid        <= 1'b1;
                        out_rd           <= in_rd;
                        out_write_enable <= in_write_enable;
                        out_mem_to_reg   <= in_mem_to_reg;
                        out_alu_out      <= in_alu_out;
                    end
                end
                c_ST_ACCESS: begin
                    if (mem_ready) begin
                        r_state          <= c_ST_IDLE;
                        mem_req          <= 1'b0;
                        mem_we           <= 1'b0;
                        out_valid        <= 1'b1;
                        out_rd           <= r_rd;
                        out_write_enable <= r_write_enable;
                        out_mem_to_reg   <= r_mem_to_reg;
                        out_alu_out      <= r_alu_out;
                        out_mem_data     <= r_is_load ? w_load_data : 32'd0;
                    end else if (w_last) begin
                        r_state        <= c_ST_IDLE;
                        mem_req        <= 1'b0;
                        mem_we         <= 1'b0;
                        out_valid      <= 1'b1;
                        out_timeout    <= 1'b1;
                        out_rd         <= r_rd;
                        out_mem_to_reg <= r_mem_to_reg;
                        out_alu_out    <= r_alu_out;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stage_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stage_memory
//  Description : Self-checking bench for stage_memory: a table of directed
//                vectors, a reset-during-access sequence and randomized
//                operations checked against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_memory;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_alu_out;
    logic [31:0] in_mem_in_data;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic        in_mem_read, in_mem_write, in_mem_to_reg, in_write_enable;
    logic        out_stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [4:0]  out_rd;
    logic        out_write_enable, out_mem_to_reg;
    logic [31:0] out_alu_out, out_mem_data;
    logic        out_misaligned, out_timeout;

    always #5 clk = ~clk;

    stage_memory #(.LATENCY_MAX(LAT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_alu_out(in_alu_out), .in_mem_in_data(in_mem_in_data),
        .in_funct3(in_funct3), .in_rd(in_rd), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write), .in_mem_to_reg(in_mem_to_reg),
        .in_write_enable(in_write_enable), .out_stall(out_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_rd(out_rd), .out_write_enable(out_write_enable),
        .out_mem_to_reg(out_mem_to_reg), .out_alu_out(out_alu_out),
        .out_mem_data(out_mem_data), .out_misaligned(out_misaligned),
        .out_timeout(out_timeout)
    );

    // One operation: inputs, memory behaviour (delay = req cycle carrying
    // ready, 0 = never) and the expected outcome.
    typedef struct {
        logic        valid, rd_op, wr_op, we, m2r;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] addr, sdata, rdata;
        int          delay;
        logic        mis, to;
        logic [3:0]  be;
        logic [31:0] wdata, mdata;
    } op_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic op_t mk(input logic valid, input logic rd_op, input logic wr_op,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] sdata, input logic [31:0] rdata,
                               input logic [4:0] rd, input logic we, input logic m2r,
                               input int delay, input logic mis, input logic to,
                               input logic [3:0] be, input logic [31:0] wdata,
                               input logic [31:0] mdata);
        op_t o;
        o.valid = valid; o.rd_op = rd_op; o.wr_op = wr_op; o.f3 = f3; o.addr = addr;
        o.sdata = sdata; o.rdata = rdata; o.rd = rd; o.we = we; o.m2r = m2r;
        o.delay = delay; o.mis = mis; o.to = to; o.be = be; o.wdata = wdata; o.mdata = mdata;
        return o;
    endfunction

    // Behavioural reference: access size in bytes, then plain arithmetic.
    function automatic op_t model(input op_t i);
        op_t o = i;
        int size, off;
        int unsigned v, mask;
        logic memop;
        memop = o.valid && (o.rd_op || o.wr_op);
        off   = int'(o.addr % 4);
        if (o.wr_op)                      size = (o.f3 == 0) ? 1 : (o.f3 == 1) ? 2 : 4;
        else if (o.f3 == 0 || o.f3 == 4)  size = 1;
        else if (o.f3 == 1 || o.f3 == 5)  size = 2;
        else                              size = 4;
        o.mis = memop && (off % size != 0);
        o.to  = memop && !o.mis && (o.delay == 0 || o.delay > LAT - 1);
        mask  = ((32'd1 << size) - 1) << off;
        o.be  = o.wr_op ? mask[3:0] : 4'hF;
        if (size == 1)      o.wdata = (o.sdata & 32'hFF) * 32'h0101_0101;
        else if (size == 2) o.wdata = (o.sdata & 32'hFFFF) * 32'h0001_0001;
        else                o.wdata = o.sdata;
        v = 0;
        if (memop && o.rd_op && !o.wr_op && !o.mis && !o.to) begin
            if (size == 1) begin
                v = (o.rdata >> (8 * off)) & 32'hFF;
                if (o.f3 == 0 && v >= 128) v = v - 256;
            end else if (size == 2) begin
                v = (o.rdata >> (16 * (off / 2))) & 32'hFFFF;
                if (o.f3 == 1 && v >= 32768) v = v - 65536;
            end else begin
                v = o.rdata;
            end
        end
        o.mdata = v;
        return o;
    endfunction

    // Entered and left at a falling edge; inputs stay frozen while stalled.
    task automatic run_op(input op_t o);
        logic memop, issue, done;
        logic [31:0] junk;
        memop = o.valid && (o.rd_op || o.wr_op);
        issue = memop && !o.mis;
        junk  = $urandom;
        in_valid = o.valid; in_alu_out = o.addr; in_mem_in_data = o.sdata;
        in_funct3 = o.f3; in_rd = o.rd; in_mem_read = o.rd_op; in_mem_write = o.wr_op;
        in_mem_to_reg = o.m2r; in_write_enable = o.we;
        mem_ready = junk[0];            // ignored outside an access
        mem_rdata = $urandom;
        #1 chk("stall_first", 32'(out_stall), 32'(issue));
        @(posedge clk); @(negedge clk);
        if (issue) begin
            for (int c = 1; c <= LAT - 1; c++) begin
                chk("req_high", 32'(mem_req), 32'd1);
                chk("req_addr", mem_addr, {o.addr[31:2], 2'b00});
                chk("req_we", 32'(mem_we), 32'(o.wr_op));
                if (o.wr_op) begin
                    chk("req_be", 32'(mem_be), 32'(o.be));
                    chk("req_wdata", mem_wdata, o.wdata);
                end
                chk("bubble_valid", 32'(out_valid), 32'd0);
                done = (c == o.delay) || (c == LAT - 1);
                mem_ready = (c == o.delay);
                mem_rdata = (c == o.delay) ? o.rdata : $urandom;
                #1 chk("stall_access", 32'(out_stall), 32'(!done));
                @(posedge clk); @(negedge clk);
                if (done) break;
            end
            mem_ready = 1'b0;
        end
        chk("req_after", 32'(mem_req), 32'd0);
        chk("out_valid", 32'(out_valid), 32'(o.valid));
        chk("out_we", 32'(out_write_enable), 32'(o.valid && o.we && !o.mis && !o.to));
        if (o.valid) begin
            chk("out_misaligned", 32'(out_misaligned), 32'(o.mis));
            chk("out_timeout", 32'(out_timeout), 32'(o.to));
            if (!o.mis && !o.to) begin
                chk("out_rd", 32'(out_rd), 32'(o.rd));
                chk("out_alu_out", out_alu_out, o.addr);
                chk("out_mem_to_reg", 32'(out_mem_to_reg), 32'(o.m2r));
                chk("out_mem_data", out_mem_data, o.mdata);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_be"}, 32'(mem_be), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_rd"}, 32'(out_rd), 32'd0);
        chk({tag, "_owe"}, 32'(out_write_enable), 32'd0);
        chk({tag, "_m2r"}, 32'(out_mem_to_reg), 32'd0);
        chk({tag, "_alu"}, out_alu_out, 32'd0);
        chk({tag, "_mdata"}, out_mem_data, 32'd0);
        chk({tag, "_mis"}, 32'(out_misaligned), 32'd0);
        chk({tag, "_to"}, 32'(out_timeout), 32'd0);
        chk({tag, "_stall"}, 32'(out_stall), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1);
    end

    initial begin
        op_t tbl[14];
        op_t r;
        logic [31:0] a;
        int kind;

        tbl[0]  = mk(1, 0, 0, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 1, 0, 1, 0, 0, 4'h0, 32'h0, 32'h0);
        tbl[1]  = mk(1, 1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 5'd6, 1, 1, 3, 0, 0, 4'hF, 32'h0, 32'hFFFF_FF80);
        tbl[2]  = mk(1, 1, 0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 5'd7, 1, 1, 3, 0, 0, 4'hF, 32'h0, 32'h0000_0080);
        tbl[3]  = mk(1, 0, 1, 3'b001, 32'h0000_0102, 32'hABCD_1234, 32'h0, 5'd0, 0, 0, 2, 0, 0, 4'b1100, 32'h1234_1234, 32'h0);
        tbl[4]  = mk(1, 1, 0, 3'b010, 32'h0000_0102, 32'h0, 32'h0, 5'd8, 1, 1, 1, 1, 0, 4'hF, 32'h0, 32'h0);
        tbl[5]  = mk(1, 1, 0, 3'b001, 32'h0000_0101, 32'h0, 32'h0, 5'd9, 1, 1, 1, 1, 0, 4'hF, 32'h0, 32'h0);
        tbl[6]  = mk(1, 0, 1, 3'b001, 32'h0000_0103, 32'h0, 32'h0, 5'd0, 0, 0, 1, 1, 0, 4'h0, 32'h0, 32'h0);
        tbl[7]  = mk(1, 1, 0, 3'b001, 32'h0000_0202, 32'h0, 32'h8001_0000, 5'd10, 1, 1, 2, 0, 0, 4'hF, 32'h0, 32'hFFFF_8001);
        tbl[8]  = mk(1, 1, 0, 3'b101, 32'h0000_0202, 32'h0, 32'h8001_0000, 5'd11, 1, 1, 1, 0, 0, 4'hF, 32'h0, 32'h0000_8001);
        tbl[9]  = mk(1, 1, 0, 3'b010, 32'h0000_0200, 32'h0, 32'hDEAD_BEEF, 5'd12, 1, 1, 1, 0, 0, 4'hF, 32'h0, 32'hDEAD_BEEF);
        tbl[10] = mk(1, 0, 1, 3'b000, 32'h0000_0201, 32'h1234_5655, 32'h0, 5'd0, 0, 0, 1, 0, 0, 4'b0010, 32'h5555_5555, 32'h0);
        tbl[11] = mk(1, 1, 0, 3'b010, 32'h0000_0300, 32'h0, 32'h1111_2222, 5'd13, 1, 1, 0, 0, 1, 4'hF, 32'h0, 32'h0);
        tbl[12] = mk(1, 0, 1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'h0, 5'd0, 0, 0, 3, 0, 0, 4'hF, 32'hCAFE_F00D, 32'h0);
        tbl[13] = mk(1, 1, 0, 3'b011, 32'h0000_0304, 32'h0, 32'h0102_0304, 5'd14, 1, 1, 2, 0, 0, 4'hF, 32'h0, 32'h0102_0304);

        reset = 1'b1; in_valid = 0; in_alu_out = 0; in_mem_in_data = 0; in_funct3 = 0;
        in_rd = 0; in_mem_read = 0; in_mem_write = 0; in_mem_to_reg = 0; in_write_enable = 0;
        mem_ready = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 14; i++) run_op(tbl[i]);

        // Reset while a load is waiting: request must drop at that edge.
        in_valid = 1; in_alu_out = 32'h40; in_funct3 = 3'b010; in_rd = 5'd3;
        in_mem_read = 1; in_mem_write = 0; in_mem_to_reg = 1; in_write_enable = 1;
        @(posedge clk); @(negedge clk);
        chk("rst_seq_req", 32'(mem_req), 32'd1);
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0; in_valid = 0; in_mem_read = 0;
        #1 chk_all_zero("rst_access");

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 7);
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            r = mk(kind != 7, (kind >= 2 && kind <= 4) || (kind == 7 && a[5]),
                   kind == 5 || kind == 6, 3'($urandom_range(0, 7)), a, $urandom, $urandom,
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 4),
                   0, 0, 4'h0, 32'h0, 32'h0);
            run_op(model(r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
